univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  WIDTH-bit universal register: sync reset/set/enable, parallel load, and
//  logical/rotate/arithmetic shifts. Shifts run one step per enabled cycle, or
//  as a multi-step sequence started by start/shamt and ended by a done pulse.
//  General-purpose state/shift element for datapaths and serialisers.
// PARAMETERS
//  WIDTH      8            data width (>=2)
//  RESET_VAL  {WIDTH{1'b0}} q value loaded by reset
//  SET_VAL    {WIDTH{1'b1}} q value loaded by set
//  CNT_W      $clog2(WIDTH+1) derived; width of shamt and step counter
// PORTS
//  clock   in   1      rising-edge clock
//  reset   in   1      sync active-high reset, highest priority
//  set     in   1      sync active-high set, second priority
//  enable  in   1      step/operation enable
//  mode    in   3      0 HOLD,1 LOAD,2 SHL,3 SHR,4 ROL,5 ROR,6 ASR,7 HOLD
//  d       in   WIDTH  parallel load data
//  sin     in   1      serial in (SHL fills LSB, SHR fills MSB)
//  start   in   1      start multi-step shift (shift modes only)
//  shamt   in   CNT_W  steps for started shift; values >WIDTH clamp to WIDTH
//  q       out  WIDTH  register value
//  qbar    out  WIDTH  always exactly ~q, including in reset/set
//  sout    out  1      registered bit shifted out by the latest step
//  busy    out  1      multi-step sequence in progress
//  done    out  1      one-cycle pulse: started sequence complete
// BEHAVIOUR
//  Reset: clock clock; reset reset, synchronous, active-high.
//  - After reset: q=RESET_VAL, qbar=~RESET_VAL, sout=0, busy=0, done=0, FSM IDLE.
//  Priority at each edge: reset > set > (busy sequence | enable op).
//  - set: q<=SET_VAL, sout<=0, busy<=0, done<=0, FSM->IDLE (aborts sequence, no done).
//  Step ops (one step): SHL q<={q[W-2:0],sin}, sout<=q[W-1];
//   SHR q<={sin,q[W-1:1]}, sout<=q[0]; ROL/ROR rotate by 1, sout<=bit wrapped;
//   ASR q<={q[W-1],q[W-1:1]}, sout<=q[0]. LOAD q<=d, sout unchanged. HOLD: no change.
//  IDLE, enable=1, start=0: perform mode once this edge (continuous shifting).
//  IDLE, enable=1, start=1, shift mode, k=min(shamt,WIDTH):
//   - k=0: q unchanged, done=1 next cycle, busy stays 0.
//   - k=1: one step this edge, done=1 next cycle, busy stays 0.
//   - k>=2: step 1 this edge, latch mode, cnt<=k-1, busy<=1, FSM->SHIFT.
//  start with HOLD/LOAD: ignored, op performed as if start=0, no done.
//  enable=0 in IDLE: no change; start ignored.
//  SHIFT: each edge with enable=1 does one step with latched mode, cnt--;
//   edge doing last step: busy<=0, done<=1, FSM->IDLE. enable=0 pauses (no step,
//   cnt held). mode/d/start/shamt ignored while busy; sin sampled every step.
//  Total latency for k steps with enable held: done high k cycles after start edge,
//   coincident with final q; done deasserts next cycle.
//  done never asserted in same cycle as busy.
// TESTING
//  1 reset=1 one edge -> q=8'h00, qbar=8'hFF, busy=0, done=0, sout=0.
//  2 reset=1,set=1 -> q=00; then set=1,enable=1,mode=LOAD,d=3C -> q=FF, qbar=00.
//  3 LOAD A5; start,mode=SHL,shamt=3,sin=0 -> busy 2 cycles, q=28 with done=1, sout=1.
//  4 LOAD 81; ROR shamt=8 with enable low 2 cycles mid-run -> done after 10 edges, q=81.
//  5 LOAD 90; ASR shamt=2 -> q=E4, done pulse; shamt=0 -> q unchanged, done next cycle.
//  6 start SHL shamt=5, set at 2nd busy cycle -> q=FF, busy=0, no done; reset mid-run -> q=00.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: sync reset/set, parallel load, logical/rotate/arithmetic
// shifts, either one step per enabled cycle or as a counted multi-step sequence.
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1,
  parameter int              CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       mode_lat, mode_next;
  logic [WIDTH-1:0] q_next;
  logic             sout_next;
  logic             done_next;
  logic [CNT_W-1:0] steps;
  logic [2:0]       op_mode;
  logic [WIDTH:0]   stepped;

  function automatic logic is_shift(input logic [2:0] m);
    return (m >= M_SHL) && (m <= M_ASR);
  endfunction

  function automatic logic [CNT_W-1:0] clamp_steps(input logic [CNT_W-1:0] n);
    if (n > CNT_W'(WIDTH)) return CNT_W'(WIDTH);
    return n;
  endfunction

  // Returns {sout, q} after a single operation of mode m.
  function automatic logic [WIDTH:0] step_op(input logic [2:0]       m,
                                             input logic [WIDTH-1:0] v,
                                             input logic             s,
                                             input logic             so,
                                             input logic [WIDTH-1:0] ld);
    logic signed [WIDTH-1:0] vs;
    vs = v;
    case (m)
      M_LOAD:  return {so, ld};
      M_SHL:   return {v[WIDTH-1], v[WIDTH-2:0], s};
      M_SHR:   return {v[0], s, v[WIDTH-1:1]};
      M_ROL:   return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   return {v[0], v[0], v[WIDTH-1:1]};
      M_ASR:   return {v[0], vs >>> 1};
      default: return {so, v};
    endcase
  endfunction

  assign steps   = clamp_steps(shamt);
  assign op_mode = (state == SHIFT) ? mode_lat : mode;
  assign stepped = step_op(op_mode, q, sin, sout, d);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mode_next  = mode_lat;
    q_next     = q;
    sout_next  = sout;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          {sout_next, q_next} = stepped;
          if (start && is_shift(mode)) begin
            if (steps == '0) begin
              // A zero-length sequence still acknowledges with done.
              q_next    = q;
              sout_next = sout;
              done_next = 1'b1;
            end else if (steps == CNT_W'(1)) begin
              done_next = 1'b1;
            end else begin
              cnt_next   = steps - CNT_W'(1);
              mode_next  = mode;
              state_next = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        if (enable) begin
          {sout_next, q_next} = stepped;
          cnt_next = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_lat <= M_HOLD;
      q        <= RESET_VAL;
      sout     <= 1'b0;
      done     <= 1'b0;
    end else if (set) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_lat <= M_HOLD;
      q        <= SET_VAL;
      sout     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      mode_lat <= mode_next;
      q        <= q_next;
      sout     <= sout_next;
      done     <= done_next;
    end
  end

  assign qbar = ~q;
  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomized and directed bench for univ_shift_reg against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int W    = 8;
  localparam int MASK = 255;

  logic       clock = 1'b0;
  logic       reset, set, enable, sin, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] shamt;
  logic [7:0] q, qbar;
  logic       sout, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int mq = 0, msout = 0, mrem = 0, mmode = 0, mdone = 0;

  univ_shift_reg dut (
    .clock  (clock),
    .reset  (reset),
    .set    (set),
    .enable (enable),
    .mode   (mode),
    .d      (d),
    .sin    (sin),
    .start  (start),
    .shamt  (shamt),
    .q      (q),
    .qbar   (qbar),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_apply(input int m);
    case (m)
      1: mq = int'(d);
      2: begin msout = (mq >> 7) & 1; mq = ((mq << 1) | int'(sin)) & MASK; end
      3: begin msout = mq & 1; mq = (mq >> 1) | (int'(sin) << 7); end
      4: begin msout = (mq >> 7) & 1; mq = ((mq << 1) | (mq >> 7)) & MASK; end
      5: begin msout = mq & 1; mq = (mq >> 1) | ((mq & 1) << 7); end
      6: begin msout = mq & 1; mq = (mq >> 1) | (mq & 128); end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    int k;
    if (reset) begin
      mq = 0; msout = 0; mrem = 0; mdone = 0;
    end else if (set) begin
      mq = MASK; msout = 0; mrem = 0; mdone = 0;
    end else begin
      mdone = 0;
      if (mrem > 0) begin
        if (enable) begin
          m_apply(mmode);
          mrem--;
          if (mrem == 0) mdone = 1;
        end
      end else if (enable) begin
        if (start && mode >= 2 && mode <= 6) begin
          k = (int'(shamt) > W) ? W : int'(shamt);
          if (k == 0) mdone = 1;
          else begin
            m_apply(int'(mode));
            if (k == 1) mdone = 1;
            else begin mrem = k - 1; mmode = int'(mode); end
          end
        end else begin
          m_apply(int'(mode));
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    check("q", q, mq);
    check("qbar", qbar, (~mq) & MASK);
    check("sout", sout, msout);
    check("busy", busy, (mrem > 0) ? 1 : 0);
    check("done", done, mdone);
  endtask

  task automatic drive(input logic r, input logic s, input logic en, input logic [2:0] m,
                       input logic [7:0] dd, input logic si, input logic st, input logic [3:0] sh);
    reset = r; set = s; enable = en; mode = m; d = dd; sin = si; start = st; shamt = sh;
  endtask

  initial begin
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);

    // 1: reset state
    cycle();
    check("t1_q", q, 8'h00);
    check("t1_qbar", qbar, 8'hFF);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_sout", sout, 0);

    // 2: reset beats set, set beats load
    drive(1, 1, 0, 0, 8'h00, 0, 0, 0); cycle();
    check("t2_rst_q", q, 8'h00);
    drive(0, 1, 1, 1, 8'h3C, 0, 0, 0); cycle();
    check("t2_set_q", q, 8'hFF);
    check("t2_set_qbar", qbar, 8'h00);

    // 3: SHL by 3
    drive(0, 0, 1, 1, 8'hA5, 0, 0, 0); cycle();
    drive(0, 0, 1, 2, 8'h00, 0, 1, 3); cycle();
    check("t3_busy1", busy, 1);
    drive(0, 0, 1, 0, 8'h00, 0, 0, 0); cycle();
    check("t3_busy2", busy, 1);
    cycle();
    check("t3_q", q, 8'h28);
    check("t3_done", done, 1);
    check("t3_sout", sout, 1);
    check("t3_busy_end", busy, 0);
    cycle();
    check("t3_done_clr", done, 0);

    // 4: ROR by 8 with a two-cycle pause
    drive(0, 0, 1, 1, 8'h81, 0, 0, 0); cycle();
    drive(0, 0, 1, 5, 8'h00, 0, 1, 8); cycle();
    drive(0, 0, 1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    enable = 0;
    for (int i = 0; i < 2; i++) cycle();
    enable = 1;
    for (int i = 0; i < 3; i++) cycle();
    check("t4_not_done_yet", done, 0);
    cycle();
    check("t4_done", done, 1);
    check("t4_q", q, 8'h81);

    // 5: ASR by 2, then zero-length start
    drive(0, 0, 1, 1, 8'h90, 0, 0, 0); cycle();
    drive(0, 0, 1, 6, 8'h00, 0, 1, 2); cycle();
    drive(0, 0, 1, 0, 8'h00, 0, 0, 0); cycle();
    check("t5_q", q, 8'hE4);
    check("t5_done", done, 1);
    drive(0, 0, 1, 6, 8'h00, 0, 1, 0); cycle();
    check("t5_zero_q", q, 8'hE4);
    check("t5_zero_done", done, 1);
    check("t5_zero_busy", busy, 0);

    // 6: set and reset abort a running sequence
    drive(0, 0, 1, 2, 8'h00, 1, 1, 5); cycle();
    drive(0, 0, 1, 0, 8'h00, 1, 0, 0); cycle();
    drive(0, 1, 1, 0, 8'h00, 1, 0, 0); cycle();
    check("t6_set_q", q, 8'hFF);
    check("t6_set_busy", busy, 0);
    check("t6_set_done", done, 0);
    drive(0, 0, 1, 2, 8'h00, 0, 1, 5); cycle();
    drive(0, 0, 1, 2, 8'h00, 0, 0, 0); cycle();
    drive(1, 0, 1, 2, 8'h00, 0, 0, 0); cycle();
    check("t6_rst_q", q, 8'h00);
    check("t6_rst_busy", busy, 0);
    reset = 0; cycle();
    check("t6_done_after", done, 0);

    // clamp: shamt beyond WIDTH behaves as WIDTH
    drive(0, 0, 1, 1, 8'h5A, 0, 0, 0); cycle();
    drive(0, 0, 1, 4, 8'h00, 0, 1, 15); cycle();
    drive(0, 0, 1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle();
    check("clamp_done", done, 1);
    check("clamp_q", q, 8'h5A);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 47) == 0),
            ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
